// File: rtl/ahb_slv_pkg.sv
// Shared AHB-Lite slave types: transfer/response encodings, FSM states and
// the little-endian byte-lane helpers used by the memory slave.
package ahb_slv_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_READY = 2'b00,
        S_ERR1  = 2'b01,
        S_ERR2  = 2'b10,
        S_WAIT  = 2'b11
    } slv_state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Illegal sizes report as misaligned so one check covers both rules.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// DEPTH x 32 storage with per-byte write enables, synchronous write and
// combinational read; the caller registers read data.
module ahb_slv_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Byte-lane write port; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave with two-cycle ERROR response and write-to-read
// forwarding. Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per legal transfer.
module ahb_lite_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hselx,
    input  logic [31:0] Haddr,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [2:0]  Hburst,
    input  logic [31:0] Hwdata,
    input  logic        Hreadyin,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);
    import ahb_slv_pkg::*;

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] WIN_MASK = ~(32'(DEPTH * 4) - 32'd1);
`ifdef AHB_SLV_WAIT_EN
    localparam slv_state_t  ACCEPT_STATE = S_WAIT;
`else
    localparam slv_state_t  ACCEPT_STATE = S_READY;
`endif

    htrans_t       trans_s;
    slv_state_t    state_r;
    slv_state_t    state_n_s;
    hresp_t        resp_s;
    logic          ready_s;
    logic          accept_s;
    logic          take_s;
    logic          in_range_s;
    logic          aligned_s;
    logic          legal_s;
    logic [AW-1:0] index_s;
    logic [AW-1:0] rd_addr_s;
    logic [3:0]    lanes_s;
    logic          wr_pend_r;
    logic [AW-1:0] wr_index_r;
    logic [3:0]    wr_lanes_r;
    logic          commit_s;
    logic [3:0]    we_s;
    logic          rd_load_s;
    logic [31:0]   mem_rdata_s;
    logic [31:0]   merged_s;
    logic [31:0]   hrdata_r;
    logic          unused_s;

    assign trans_s    = htrans_t'(Htrans);
    assign accept_s   = Hselx & Hreadyin & ((trans_s == HTRANS_NONSEQ) | (trans_s == HTRANS_SEQ));
    assign take_s     = accept_s & ready_s;
    assign in_range_s = ((Haddr & WIN_MASK) == BASE_ADDR);
    assign aligned_s  = size_aligned(Hsize, Haddr[1:0]);
    assign legal_s    = in_range_s & aligned_s;
    assign index_s    = Haddr[AW+1:2];
    assign lanes_s    = lane_mask(Hsize, Haddr[1:0]);
    assign unused_s   = ^Hburst;

    // A write commits in the data-phase cycle that shows ready; reset drops it.
    assign commit_s = wr_pend_r & ready_s & ~Hreset;
    assign we_s     = commit_s ? wr_lanes_r : 4'b0000;

`ifdef AHB_SLV_WAIT_EN
    logic [3:0]    cnt_r;
    logic          rd_pend_r;
    logic [AW-1:0] rd_index_r;

    // Wait counter and read context captured at address acceptance.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            cnt_r      <= 4'd0;
            rd_pend_r  <= 1'b0;
            rd_index_r <= {AW{1'b0}};
        end else if (take_s) begin
            cnt_r      <= 4'(WAIT_CYCLES);
            rd_pend_r  <= legal_s & ~Hwrite;
            rd_index_r <= index_s;
        end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Load read data on the edge entering the final (ready) wait cycle.
    assign rd_addr_s = rd_index_r;
    assign rd_load_s = (state_r == S_WAIT) && (cnt_r == 4'd1) && rd_pend_r;
`else
    assign rd_addr_s = index_s;
    assign rd_load_s = take_s & legal_s & ~Hwrite;
`endif

    ahb_slv_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (Hclk),
        .we    (we_s),
        .waddr (wr_index_r),
        .wdata (Hwdata),
        .raddr (rd_addr_s),
        .rdata (mem_rdata_s)
    );

    // Lanes being written this same edge are taken from Hwdata, not stale memory.
    always_comb begin
        merged_s = mem_rdata_s;
        for (int i = 0; i < 4; i++) begin
            if (commit_s && (wr_index_r == rd_addr_s) && wr_lanes_r[i]) begin
                merged_s[8*i +: 8] = Hwdata[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = mem_rdata_s[8*i +: 8];
            end
        end
    end

    // Pending write context for the upcoming data phase.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            wr_pend_r  <= 1'b0;
            wr_index_r <= {AW{1'b0}};
            wr_lanes_r <= 4'b0000;
        end else if (take_s) begin
            wr_pend_r  <= legal_s & Hwrite;
            wr_index_r <= index_s;
            wr_lanes_r <= lanes_s;
        end else if (commit_s) begin
            wr_pend_r <= 1'b0;
        end
    end

    // Read data register; holds across writes, idles and errors.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            hrdata_r <= 32'h0000_0000;
        end else if (rd_load_s) begin
            hrdata_r <= merged_s;
        end
    end

    // FSM state register.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_r <= S_READY;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        if (state_r == S_ERR1) begin
            state_n_s = S_ERR2;
        end else if (!ready_s) begin
            state_n_s = state_r;
        end else if (take_s) begin
            state_n_s = legal_s ? ACCEPT_STATE : S_ERR1;
        end else begin
            state_n_s = S_READY;
        end
    end

    // FSM output decode.
    always_comb begin
        ready_s = 1'b1;
        resp_s  = HRESP_OKAY;
        case (state_r)
            S_READY: begin
                ready_s = 1'b1;
                resp_s  = HRESP_OKAY;
            end
            S_ERR1: begin
                ready_s = 1'b0;
                resp_s  = HRESP_ERROR;
            end
            S_ERR2: begin
                ready_s = 1'b1;
                resp_s  = HRESP_ERROR;
            end
            S_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
                ready_s = (cnt_r == 4'd0);
`else
                ready_s = 1'b1;
`endif
                resp_s  = HRESP_OKAY;
            end
            default: begin
                ready_s = 1'b1;
                resp_s  = HRESP_OKAY;
            end
        endcase
    end

    assign Hreadyout = ready_s;
    assign Hresp     = resp_s;
    assign Hrdata    = hrdata_r;

endmodule
